// File: rtl/core2wb_pkg.sv
// +--------------------------------------------------------------------+
// | core2wb_pkg: shared FSM state type and counter sizing helper       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package core2wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ABORT  = 2'd2
   } state_e;

   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_watchdog.sv
// +--------------------------------------------------------------------+
// | wb_watchdog: flags a stalled bus after TIMEOUT silent cycles       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer_q, timer_d;

   always_comb begin
      timer_d = timer_q;
      if (clear) begin
         timer_d = '0;
      end else if (run) begin
         timer_d = timer_q + 1'b1;
      end
      expired = run & ~clear & (timer_q == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/core2wb_bridge.sv
// +--------------------------------------------------------------------+
// | core2wb_bridge: Ibex LSU data port to Wishbone B4 pipelined master |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module core2wb_bridge
   import core2wb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT         = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   output logic        data_gnt,
   output logic        data_rvalid,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_err,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [3:0]  wb_sel,
   output logic [29:0] wb_adr,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   input  logic        wb_err,
   input  logic        wb_stall,
   output logic        proto_err
);

   localparam int CW = cnt_width(MAX_OUTSTANDING);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          proto_err_q, proto_err_d;

   logic cnt_nz, full, not_abort, slave_rsp, rsp_valid;
   logic wd_clear, wd_expired;
   logic unused_addr_lsb;

   assign wb_we           = data_we;
   assign wb_sel          = data_be;
   assign wb_adr          = data_addr[31:2];
   assign wb_dat_o        = data_wdata;
   assign proto_err       = proto_err_q;
   assign unused_addr_lsb = ^data_addr[1:0];

   always_comb begin
      cnt_nz    = (cnt_q != '0);
      full      = (cnt_q == CNT_MAX);
      not_abort = (state_q != ST_ABORT);
      slave_rsp = wb_ack | wb_err;

      // Zero-latency issue: strobe and grant follow the request combinationally
      wb_stb    = not_abort & data_req & ~full;
      data_gnt  = wb_stb & ~wb_stall;
      wb_cyc    = not_abort & (data_req | cnt_nz);
      rsp_valid = not_abort & slave_rsp & cnt_nz;

      if (not_abort) begin
         data_rvalid = rsp_valid;
         data_err    = wb_err;
         data_rdata  = wb_err ? 32'h0 : wb_dat_i;
      end else begin
         data_rvalid = 1'b1;
         data_err    = 1'b1;
         data_rdata  = 32'h0;
      end

      wd_clear = rsp_valid | ~cnt_nz | ~not_abort;

      cnt_d       = cnt_q;
      state_d     = state_q;
      proto_err_d = proto_err_q | (not_abort & slave_rsp & ~cnt_nz);

      if (!not_abort) begin
         // Drain one error response per cycle; cyc stays low until IDLE
         if (cnt_nz) begin
            cnt_d = cnt_q - 1'b1;
         end
         if (cnt_q <= CNT_ONE) begin
            state_d = ST_IDLE;
         end
      end else begin
         case ({data_gnt, rsp_valid})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         if (wd_expired) begin
            state_d = ST_ABORT;
         end else if (cnt_d != '0) begin
            state_d = ST_ACTIVE;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .run     (cnt_nz),
      .expired (wd_expired)
   );

endmodule

`default_nettype wire
